pcm_trigger_collector: RTL and testbench

//  Consumer side of the per-channel PCM peak detectors. Arms NUM_CH detectors, waits until all

---
 rtl/pcm_collect_pkg.sv | 14 +
 rtl/pcm_min_tree.sv | 28 ++
 rtl/pcm_trigger_collector.sv | 155 +++++++++++++++
 tb/tb_pcm_trigger_collector.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pcm_collect_pkg.sv
// Shared types and constants for the PCM trigger collector.
package pcm_collect_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_ARMED = 2'd2,
    S_EMIT  = 2'd3
  } pcm_state_e;

  localparam int unsigned CLEAR_CYCLES = 2;
  localparam logic [63:0] NO_HIT       = '1;

endpackage

// File: rtl/pcm_min_tree.sv
// Combinational masked minimum over NUM_CH packed ages; the lowest index wins a tie.
module pcm_min_tree #(
  parameter int NUM_CH = 4,
  parameter int TW     = 32
) (
  input  logic [NUM_CH*TW-1:0] ages_i,
  input  logic [NUM_CH-1:0]    mask_i,
  output logic [TW-1:0]        min_o
);

  logic          found;
  logic [TW-1:0] best;

  always_comb begin
    found = 1'b0;
    best  = '0;
    // Strict compare keeps the earliest index among equal ages.
    for (int i = 0; i < NUM_CH; i++) begin
      if (mask_i[i] && (!found || ages_i[i*TW +: TW] < best)) begin
        best  = ages_i[i*TW +: TW];
        found = 1'b1;
      end
    end
  end

  assign min_o = best;

endmodule

// File: rtl/pcm_trigger_collector.sv
// Arms the PCM peak detectors, waits for all triggers or a timeout, then streams one time per channel.
// Build option PCM_COLLECT_ABS_EN: emit absolute trigger times instead of deltas to the earliest hit.
//
// state   | meaning
// IDLE    | waiting for arm
// CLEAR   | detectors held in reset for CLEAR_CYCLES cycles
// ARMED   | waiting for all triggers or timeout
// EMIT    | streaming one beat per channel
module pcm_trigger_collector
  import pcm_collect_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int TIMEOUT = 48000,
  parameter int TW      = 32
) (
  input  logic                       pcm_clk,
  input  logic                       reset_n,
  input  logic [TW-1:0]              sample_counter,
  input  logic                       arm,
  input  logic [NUM_CH-1:0]          triggered,
  input  logic [NUM_CH*TW-1:0]       triggered_time,
  output logic                       det_reset,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TW-1:0]              out_data,
  output logic [$clog2(NUM_CH)-1:0]  out_channel,
  output logic                       out_last,
  output logic                       timed_out
);

  localparam int CW = $clog2(NUM_CH);

  pcm_state_e              state_q, state_d;
  logic                    clr_q, clr_d;
  logic [31:0]             timer_q, timer_d;
  logic [NUM_CH-1:0]       snap_trig_q, snap_trig_d;
  logic [NUM_CH*TW-1:0]    snap_time_q, snap_time_d;
  logic [CW-1:0]           ch_q, ch_d;
  logic                    timed_out_q, timed_out_d;
  logic                    clr_last;
  logic [TW-1:0]           beat;

  assign clr_last = (clr_q == 1'(CLEAR_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    clr_d       = clr_q;
    timer_d     = timer_q;
    snap_trig_d = snap_trig_q;
    snap_time_d = snap_time_q;
    ch_d        = ch_q;
    timed_out_d = timed_out_q;
    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d     = S_CLEAR;
          clr_d       = 1'b0;
          timed_out_d = 1'b0;
        end
      end
      S_CLEAR: begin
        if (clr_last) begin
          state_d = S_ARMED;
          timer_d = '0;
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end
      S_ARMED: begin
        timer_d = timer_q + 32'd1;
        // All-triggered takes priority over a timeout landing on the same cycle.
        if (&triggered || timer_q == 32'(TIMEOUT - 1)) begin
          state_d     = S_EMIT;
          snap_trig_d = triggered;
          snap_time_d = triggered_time;
          ch_d        = '0;
          timed_out_d = ~(&triggered);
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (ch_q == CW'(NUM_CH - 1)) begin
            state_d = S_IDLE;
            ch_d    = '0;
          end else begin
            ch_d = ch_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pcm_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      clr_q       <= 1'b0;
      timer_q     <= '0;
      snap_trig_q <= '0;
      snap_time_q <= '0;
      ch_q        <= '0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_q       <= clr_d;
      timer_q     <= timer_d;
      snap_trig_q <= snap_trig_d;
      snap_time_q <= snap_time_d;
      ch_q        <= ch_d;
      timed_out_q <= timed_out_d;
    end
  end

`ifdef PCM_COLLECT_ABS_EN
  logic unused_sc;
  assign unused_sc = ^sample_counter;
  assign beat      = snap_time_q[ch_q*TW +: TW];
`else
  logic [TW-1:0]        arm_time_q;
  logic [NUM_CH*TW-1:0] ages;
  logic [TW-1:0]        t0;

  always_ff @(posedge pcm_clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_time_q <= '0;
    end else if (state_q == S_CLEAR && clr_last) begin
      arm_time_q <= sample_counter;
    end
  end

  // Modular subtraction makes a sample_counter wrap between arm and trigger harmless.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_age
    assign ages[g*TW +: TW] = snap_time_q[g*TW +: TW] - arm_time_q;
  end

  pcm_min_tree #(.NUM_CH(NUM_CH), .TW(TW)) u_min (
    .ages_i (ages),
    .mask_i (snap_trig_q),
    .min_o  (t0)
  );

  assign beat = ages[ch_q*TW +: TW] - t0;
`endif

  assign det_reset   = (state_q == S_CLEAR);
  assign busy        = (state_q != S_IDLE);
  assign out_valid   = (state_q == S_EMIT);
  assign out_channel = ch_q;
  assign out_last    = out_valid && (ch_q == CW'(NUM_CH - 1));
  assign out_data    = !out_valid         ? '0 :
                       snap_trig_q[ch_q]  ? beat : TW'(NO_HIT);
  assign timed_out   = timed_out_q;

endmodule

// File: tb/tb_pcm_trigger_collector.sv
// Self-checking bench for pcm_trigger_collector (table vectors + scoreboard + corner sequences).
module tb_pcm_trigger_collector;

  localparam int NCH = 4;
  localparam int TO  = 100;
  localparam logic [31:0] NH = 32'hFFFF_FFFF;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [31:0]     sample_counter;
  logic            arm;
  logic [NCH-1:0]  triggered;
  logic [NCH*32-1:0] triggered_time;
  logic            det_reset, busy, out_valid, out_ready, out_last, timed_out;
  logic [31:0]     out_data;
  logic [1:0]      out_channel;

  pcm_trigger_collector #(.NUM_CH(NCH), .TIMEOUT(TO), .TW(32)) dut (
    .pcm_clk        (clk),
    .reset_n        (reset_n),
    .sample_counter (sample_counter),
    .arm            (arm),
    .triggered      (triggered),
    .triggered_time (triggered_time),
    .det_reset      (det_reset),
    .busy           (busy),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_channel    (out_channel),
    .out_last       (out_last),
    .timed_out      (timed_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]          sc;
    logic [3:0]           mask;
    int                   delay;
    logic [3:0][31:0]     t;
    logic [3:0][31:0]     e;
    logic                 to;
  } vec_t;

  typedef struct {
    int          ch;
    logic [31:0] data;
    logic        last;
  } beat_t;

  vec_t  vecs[7];
  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] sc, input logic [3:0] m, input int d,
                              input logic [31:0] t0, t1, t2, t3,
                              input logic [31:0] e0, e1, e2, e3, input logic to);
    vec_t v;
    v.sc = sc; v.mask = m; v.delay = d; v.to = to;
    v.t[0] = t0; v.t[1] = t1; v.t[2] = t2; v.t[3] = t3;
    v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3;
    return v;
  endfunction

  function automatic logic [31:0] exp_for(input vec_t v, input int i);
`ifdef PCM_COLLECT_ABS_EN
    return v.mask[i] ? v.t[i] : NH;
`else
    return v.e[i];
`endif
  endfunction

  // Scoreboard consumer: one expected beat per handshake.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat actual ch=%0d data=%0h required none", out_channel, out_data);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        chk("beat_channel", 64'(out_channel), 64'(b.ch));
        chk("beat_data", 64'(out_data), 64'(b.data));
        chk("beat_last", 64'(out_last), 64'(b.last));
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_det_reset"}, 64'(det_reset), 0);
    chk({tag, "_out_valid"}, 64'(out_valid), 0);
    chk({tag, "_out_data"}, 64'(out_data), 0);
    chk({tag, "_out_channel"}, 64'(out_channel), 0);
    chk({tag, "_out_last"}, 64'(out_last), 0);
    chk({tag, "_timed_out"}, 64'(timed_out), 0);
  endtask

  task automatic arm_and_clear(input logic [31:0] sc);
    int n;
    sample_counter = sc;
    arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
    n = 0;
    while (det_reset && n < 10) begin
      n++;
      @(posedge clk); #1;
    end
    chk("clear_cycles", 64'(n), 2);
    chk("busy_armed", 64'(busy), 1);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("return_idle", 64'(busy), 0);
    chk("all_beats_seen", 64'(exp_q.size()), 0);
  endtask

  task automatic push_beats(input vec_t v);
    for (int i = 0; i < NCH; i++)
      exp_q.push_back('{ch: i, data: exp_for(v, i), last: (i == NCH - 1)});
  endtask

  task automatic run_vector(input vec_t v);
    int cyc;
    arm_and_clear(v.sc);
    repeat (v.delay) begin
      @(posedge clk); #1;
    end
    triggered      = v.mask;
    triggered_time = v.t;
    push_beats(v);
    wait_valid(cyc);
    chk("armed_cycles", 64'(cyc + v.delay), (v.mask == 4'hF) ? 64'(v.delay + 1) : 64'(TO));
    chk("timed_out", 64'(timed_out), 64'(v.to));
    // Detector changes after EMIT entry must not reach the output.
    triggered      = ~v.mask;
    triggered_time = ~v.t;
    wait_idle();
    chk("timed_out_sticky", 64'(timed_out), 64'(v.to));
    triggered = '0;
  endtask

  initial begin
    int cyc;
    vecs[0] = mk(32'd1000, 4'hF, 0, 1010, 1005, 1020, 1005, 5, 0, 15, 0, 1'b0);
    vecs[1] = mk(32'd0, 4'h4, 40, 0, 0, 40, 0, NH, NH, 0, NH, 1'b1);
    vecs[2] = mk(32'hFFFF_FFF0, 4'hF, 3, 32'h10, 32'hFFFF_FFF8, 32'h10, 0, 24, 0, 24, 8, 1'b0);
    vecs[3] = mk(32'd500, 4'h0, 0, 1, 2, 3, 4, NH, NH, NH, NH, 1'b1);
    vecs[4] = mk(32'd7, 4'hF, 5, 20, 10, 10, 30, 10, 0, 0, 20, 1'b0);
    vecs[5] = mk(32'd100, 4'h3, 0, 150, 130, 999, 999, 20, 0, NH, NH, 1'b1);
    vecs[6] = mk(32'd1000, 4'hF, TO - 1, 1003, 1001, 1002, 1050, 2, 0, 1, 49, 1'b0);

    reset_n = 1'b0; arm = 1'b0; out_ready = 1'b1;
    sample_counter = '0; triggered = '0; triggered_time = '0;
    #12;
    chk_reset_vals("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[k]) run_vector(vecs[k]);

    // Backpressure mid-stream: beat 1 held stable, arm ignored.
    out_ready = 1'b0;
    arm_and_clear(vecs[0].sc);
    triggered = vecs[0].mask; triggered_time = vecs[0].t;
    push_beats(vecs[0]);
    wait_valid(cyc);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    arm = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 64'(out_valid), 1);
      chk("hold_channel", 64'(out_channel), 1);
      chk("hold_data", 64'(out_data), 64'(exp_for(vecs[0], 1)));
      @(posedge clk); #1;
      arm = 1'b0;
    end
    out_ready = 1'b1;
    wait_idle();
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("arm_ignored", 64'(busy), 0);
    triggered = '0;

    // Reset while ARMED.
    arm_and_clear(32'd0);
    repeat (10) begin
      @(posedge clk); #1;
    end
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("rst_armed");
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Reset mid-EMIT after a timeout.
    out_ready = 1'b0;
    arm_and_clear(32'd0);
    push_beats(vecs[3]);
    wait_valid(cyc);
    chk("emit_timeout_flag", 64'(timed_out), 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("emit_channel_mid", 64'(out_channel), 1);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("rst_emit");
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    run_vector(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
